// File: rtl/sys_ctrl_v2.sv
// sys_ctrl_v2: UART command controller. Decodes framed RX commands into
// register-file writes/reads and ALU operations, and returns read data or
// ALU results over the TX FIFO interface. Idle gaps inside a frame are
// bounded by a timeout counter.
module sys_ctrl_v2 #(
  parameter int DATA_WIDTH     = 8,
  parameter int ALU_OUT_WIDTH  = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int FUN_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [DATA_WIDTH-1:0]    i_RX_P_DATA,
  input  logic                     i_RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    i_RdData,
  input  logic                     i_RdData_Valid,
  output logic [ADDR_WIDTH-1:0]    o_Address,
  output logic                     o_RdEn,
  output logic                     o_WrEn,
  output logic [DATA_WIDTH-1:0]    o_WrData,
  input  logic [ALU_OUT_WIDTH-1:0] i_ALU_OUT,
  input  logic                     i_OUT_VALID,
  output logic [FUN_WIDTH-1:0]     o_ALU_FUN,
  output logic                     o_Enable,
  output logic                     o_Clk_Enable,
  input  logic                     i_full_FIFO,
  output logic [DATA_WIDTH-1:0]    o_TX_P_DATA,
  output logic                     o_TX_D_VLD,
  output logic                     o_clk_div_en,
  output logic                     o_err_cmd,
  output logic                     o_err_timeout,
  output logic                     o_busy
);

  localparam int N_BYTES = ALU_OUT_WIDTH / DATA_WIDTH;
  localparam int IDX_W   = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
  localparam int TMR_W   = $clog2(TIMEOUT_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_RD_TX,
    S_OPA, S_OPB, S_FUN, S_ALU_WAIT, S_ALU_TX
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0]    rd_hold_q, rd_hold_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic                     err_cmd_q, err_cmd_d;
  logic                     err_to_q, err_to_d;

  logic [7:0]               cmd_s;
  logic                     expired_s;
  logic                     rx_wait_s;
  logic                     timed_s;
  logic [DATA_WIDTH-1:0]    alu_byte_s;

  logic [ADDR_WIDTH-1:0]    addr_s;
  logic                     rd_en_s, wr_en_s, enable_s, tx_vld_s;
  logic [DATA_WIDTH-1:0]    wr_data_s, tx_data_s;
  logic [FUN_WIDTH-1:0]     alu_fun_s;

  assign cmd_s      = i_RX_P_DATA[7:0];
  assign expired_s  = (tmr_q == TMR_LAST);
  assign alu_byte_s = result_q[idx_q*DATA_WIDTH +: DATA_WIDTH];

  // States waiting on RX bytes, and states that are bounded by the timer.
  assign rx_wait_s = (state_q == S_WR_ADDR) || (state_q == S_WR_DATA) ||
                     (state_q == S_RD_ADDR) || (state_q == S_OPA) ||
                     (state_q == S_OPB)     || (state_q == S_FUN);
  assign timed_s   = rx_wait_s || (state_q == S_RD_WAIT) || (state_q == S_ALU_WAIT);

  // Strobes are combinational so they land in the same cycle as the accepted
  // byte; reset forces every strobe low immediately, before the clock edge.
  assign o_Address     = i_reset ? addr_s    : '0;
  assign o_RdEn        = i_reset & rd_en_s;
  assign o_WrEn        = i_reset & wr_en_s;
  assign o_WrData      = i_reset ? wr_data_s : '0;
  assign o_ALU_FUN     = i_reset ? alu_fun_s : '0;
  assign o_Enable      = i_reset & enable_s;
  assign o_TX_P_DATA   = i_reset ? tx_data_s : '0;
  assign o_TX_D_VLD    = i_reset & tx_vld_s;
  assign o_err_cmd     = i_reset & err_cmd_q;
  assign o_err_timeout = i_reset & err_to_q;
  assign o_busy        = i_reset & (state_q != S_IDLE);
  assign o_Clk_Enable  = 1'b1;
  assign o_clk_div_en  = 1'b1;

  // Next-state, datapath next values and strobe outputs.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    result_d  = result_q;
    rd_hold_d = rd_hold_q;
    idx_d     = idx_q;
    err_cmd_d = 1'b0;
    err_to_d  = 1'b0;
    addr_s    = '0;
    rd_en_s   = 1'b0;
    wr_en_s   = 1'b0;
    enable_s  = 1'b0;
    tx_vld_s  = 1'b0;
    wr_data_s = '0;
    tx_data_s = '0;
    alu_fun_s = '0;

    case (state_q)
      S_IDLE: begin
        if (i_RX_D_VLD) begin
          case (cmd_s)
            8'hAA:   state_d = S_WR_ADDR;
            8'hBB:   state_d = S_RD_ADDR;
            8'hCC:   state_d = S_OPA;
            8'hDD:   state_d = S_FUN;
            default: err_cmd_d = 1'b1;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WR_ADDR: begin
        if (i_RX_D_VLD) begin
          addr_d  = i_RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_WR_DATA;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_WR_ADDR;
        end
      end
      S_WR_DATA: begin
        if (i_RX_D_VLD) begin
          wr_en_s   = 1'b1;
          addr_s    = addr_q;
          wr_data_s = i_RX_P_DATA;
          state_d   = S_IDLE;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_WR_DATA;
        end
      end
      S_RD_ADDR: begin
        if (i_RX_D_VLD) begin
          rd_en_s = 1'b1;
          addr_s  = i_RX_P_DATA[ADDR_WIDTH-1:0];
          state_d = S_RD_WAIT;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_RD_ADDR;
        end
      end
      S_RD_WAIT: begin
        if (i_RdData_Valid) begin
          rd_hold_d = i_RdData;
          state_d   = S_RD_TX;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_RD_WAIT;
        end
      end
      S_RD_TX: begin
        if (!i_full_FIFO) begin
          tx_vld_s  = 1'b1;
          tx_data_s = rd_hold_q;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RD_TX;
        end
      end
      S_OPA, S_OPB: begin
        if (i_RX_D_VLD) begin
          wr_en_s   = 1'b1;
          addr_s    = (state_q == S_OPA) ? ADDR_WIDTH'(0) : ADDR_WIDTH'(1);
          wr_data_s = i_RX_P_DATA;
          state_d   = (state_q == S_OPA) ? S_OPB : S_FUN;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      S_FUN: begin
        if (i_RX_D_VLD) begin
          enable_s  = 1'b1;
          alu_fun_s = i_RX_P_DATA[FUN_WIDTH-1:0];
          state_d   = S_ALU_WAIT;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_FUN;
        end
      end
      S_ALU_WAIT: begin
        if (i_OUT_VALID) begin
          result_d = i_ALU_OUT;
          idx_d    = '0;
          state_d  = S_ALU_TX;
        end else if (expired_s) begin
          state_d  = S_IDLE;
          err_to_d = 1'b1;
        end else begin
          state_d = S_ALU_WAIT;
        end
      end
      S_ALU_TX: begin
        if (!i_full_FIFO) begin
          tx_vld_s  = 1'b1;
          tx_data_s = alu_byte_s;
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d = S_ALU_TX;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Timeout counter: restarts on any state change or accepted RX byte,
  // counts only in states bounded by the timer.
  always_comb begin
    tmr_d = '0;
    if (state_d != state_q) begin
      tmr_d = '0;
    end else if (rx_wait_s && i_RX_D_VLD) begin
      tmr_d = '0;
    end else if (timed_s) begin
      tmr_d = tmr_q + TMR_W'(1);
    end else begin
      tmr_d = '0;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      result_q  <= '0;
      rd_hold_q <= '0;
      idx_q     <= '0;
      tmr_q     <= '0;
      err_cmd_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      result_q  <= result_d;
      rd_hold_q <= rd_hold_d;
      idx_q     <= idx_d;
      tmr_q     <= tmr_d;
      err_cmd_q <= err_cmd_d;
      err_to_q  <= err_to_d;
    end
  end

endmodule

// File: tb/tb_sys_ctrl_v2.sv
// tb_sys_ctrl_v2: directed scenarios plus randomized traffic, every cycle
// compared against a frame-level reference model.
module tb_sys_ctrl_v2;
  localparam int DW = 8;
  localparam int AW = 32;
  localparam int ADW = 4;
  localparam int FW = 4;
  localparam int TO = 8;
  localparam int NB = AW / DW;

  logic i_clk = 1'b0;
  logic i_reset;
  logic [DW-1:0] i_RX_P_DATA;
  logic i_RX_D_VLD;
  logic [DW-1:0] i_RdData;
  logic i_RdData_Valid;
  logic [ADW-1:0] o_Address;
  logic o_RdEn, o_WrEn;
  logic [DW-1:0] o_WrData;
  logic [AW-1:0] i_ALU_OUT;
  logic i_OUT_VALID;
  logic [FW-1:0] o_ALU_FUN;
  logic o_Enable, o_Clk_Enable;
  logic i_full_FIFO;
  logic [DW-1:0] o_TX_P_DATA;
  logic o_TX_D_VLD, o_clk_div_en, o_err_cmd, o_err_timeout, o_busy;

  always #5 i_clk = ~i_clk;

  sys_ctrl_v2 #(.DATA_WIDTH(DW), .ALU_OUT_WIDTH(AW), .ADDR_WIDTH(ADW),
                .FUN_WIDTH(FW), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_RX_P_DATA(i_RX_P_DATA), .i_RX_D_VLD(i_RX_D_VLD),
    .i_RdData(i_RdData), .i_RdData_Valid(i_RdData_Valid),
    .o_Address(o_Address), .o_RdEn(o_RdEn), .o_WrEn(o_WrEn), .o_WrData(o_WrData),
    .i_ALU_OUT(i_ALU_OUT), .i_OUT_VALID(i_OUT_VALID),
    .o_ALU_FUN(o_ALU_FUN), .o_Enable(o_Enable), .o_Clk_Enable(o_Clk_Enable),
    .i_full_FIFO(i_full_FIFO), .o_TX_P_DATA(o_TX_P_DATA), .o_TX_D_VLD(o_TX_D_VLD),
    .o_clk_div_en(o_clk_div_en), .o_err_cmd(o_err_cmd),
    .o_err_timeout(o_err_timeout), .o_busy(o_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Single comparison point: counts and reports.
  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: which command frame is open, how many of its operand
  // bytes have arrived, whether it is waiting for a response or sending,
  // the bytes still to send, and the idle-cycle count.
  int m_kind = 0;        // 0 = no frame, else command byte
  int m_pos = 0;         // operand bytes received so far
  int m_phase = 0;       // 0 collect, 1 await response, 2 transmit
  int m_cnt = 0;
  int m_addr = 0;
  logic [7:0] m_txq[$];
  bit m_err_cmd = 1'b0;
  bit m_err_to = 1'b0;

  // Observed values of the most recent step.
  logic obs_wren, obs_rden, obs_en, obs_txvld, obs_busy, obs_errc, obs_errt;
  logic [ADW-1:0] obs_addr;
  logic [DW-1:0] obs_wrdata, obs_txdata;
  logic [FW-1:0] obs_fun;

  function automatic int need_bytes(input int kind);
    case (kind)
      'hAA: return 2;
      'hCC: return 3;
      default: return 1;
    endcase
  endfunction

  // Role of an operand byte: 1 wr addr, 2 wr data, 3 rd addr, 4 opA, 5 opB, 6 fun.
  function automatic int role_of(input int kind, input int pos);
    case (kind)
      'hAA: return (pos == 0) ? 1 : 2;
      'hBB: return 3;
      'hCC: return 4 + pos;
      default: return 6;
    endcase
  endfunction

  // One clock cycle: drive, check against the model, advance model and clock.
  task automatic step(input logic rst, input logic vld, input logic [7:0] d,
                      input logic rdv, input logic [7:0] rdd,
                      input logic ov, input logic [31:0] alu, input logic full);
    logic e_wr, e_rd, e_en, e_tx, e_busy;
    logic [ADW-1:0] e_addr;
    logic [FW-1:0] e_fun;
    logic [DW-1:0] e_wd, e_txd;
    bit n_err_cmd, n_err_to;
    int r;
    i_reset = rst; i_RX_D_VLD = vld; i_RX_P_DATA = d;
    i_RdData_Valid = rdv; i_RdData = rdd; i_OUT_VALID = ov; i_ALU_OUT = alu;
    i_full_FIFO = full;
    #1;
    obs_wren = o_WrEn; obs_rden = o_RdEn; obs_en = o_Enable; obs_txvld = o_TX_D_VLD;
    obs_busy = o_busy; obs_errc = o_err_cmd; obs_errt = o_err_timeout;
    obs_addr = o_Address; obs_wrdata = o_WrData; obs_txdata = o_TX_P_DATA; obs_fun = o_ALU_FUN;

    e_wr = 0; e_rd = 0; e_en = 0; e_tx = 0; e_busy = 0;
    e_addr = '0; e_fun = '0; e_wd = '0; e_txd = '0;
    r = role_of(m_kind, m_pos);
    if (rst) begin
      e_busy = (m_kind != 0);
      if (m_kind != 0 && m_phase == 0 && vld) begin
        case (r)
          2: begin e_wr = 1; e_addr = ADW'(m_addr); e_wd = d; end
          3: begin e_rd = 1; e_addr = d[3:0]; end
          4: begin e_wr = 1; e_addr = 4'd0; e_wd = d; end
          5: begin e_wr = 1; e_addr = 4'd1; e_wd = d; end
          6: begin e_en = 1; e_fun = d[3:0]; end
          default: ;
        endcase
      end
      if (m_phase == 2 && !full) begin e_tx = 1; e_txd = m_txq[0]; end
    end
    check_val("wren", 64'(obs_wren), 64'(e_wr));
    check_val("rden", 64'(obs_rden), 64'(e_rd));
    check_val("enable", 64'(obs_en), 64'(e_en));
    check_val("address", 64'(obs_addr), 64'(e_addr));
    check_val("wrdata", 64'(obs_wrdata), 64'(e_wd));
    check_val("alu_fun", 64'(obs_fun), 64'(e_fun));
    check_val("tx_vld", 64'(obs_txvld), 64'(e_tx));
    check_val("tx_data", 64'(obs_txdata), 64'(e_txd));
    check_val("busy", 64'(obs_busy), 64'(e_busy));
    check_val("err_cmd", 64'(obs_errc), 64'(rst ? m_err_cmd : 1'b0));
    check_val("err_timeout", 64'(obs_errt), 64'(rst ? m_err_to : 1'b0));
    check_val("clk_en", 64'({o_Clk_Enable, o_clk_div_en}), 64'(2'b11));

    n_err_cmd = 0; n_err_to = 0;
    if (!rst) begin
      m_kind = 0; m_pos = 0; m_phase = 0; m_cnt = 0; m_addr = 0; m_txq.delete();
    end else if (m_kind == 0) begin
      if (vld) begin
        if (d == 8'hAA || d == 8'hBB || d == 8'hCC || d == 8'hDD) begin
          m_kind = int'(d); m_pos = 0; m_phase = 0; m_cnt = 0;
        end else begin
          n_err_cmd = 1;
        end
      end
    end else if (m_phase == 0) begin
      if (vld) begin
        if (r == 1) m_addr = int'(d[3:0]);
        m_pos++; m_cnt = 0;
        if (m_pos == need_bytes(m_kind)) begin
          if (m_kind == 'hAA) m_kind = 0;
          else m_phase = 1;
        end
      end else if (m_cnt == TO - 1) begin
        m_kind = 0; m_phase = 0; n_err_to = 1;
      end else m_cnt++;
    end else if (m_phase == 1) begin
      if ((m_kind == 'hBB) ? rdv : ov) begin
        if (m_kind == 'hBB) m_txq.push_back(rdd);
        else for (int k = 0; k < NB; k++) m_txq.push_back(8'((alu >> (8 * k)) & 32'hFF));
        m_phase = 2;
      end else if (m_cnt == TO - 1) begin
        m_kind = 0; m_phase = 0; n_err_to = 1;
      end else m_cnt++;
    end else begin
      if (!full) begin
        void'(m_txq.pop_front());
        if (m_txq.size() == 0) begin m_kind = 0; m_phase = 0; end
      end
    end
    m_err_cmd = n_err_cmd; m_err_to = n_err_to;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rx(input logic [7:0] d);
    step(1'b1, 1'b1, d, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic idle(input logic full);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, full);
  endtask

  initial begin
    logic [7:0] cmds [4];
    logic [7:0] exp_bytes [4];
    logic rst_r, vld_r, rdv_r, ov_r, full_r;
    logic [7:0] d_r, rdd_r;
    logic [31:0] alu_r;
    cmds = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    exp_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

    i_reset = 1'b0; i_RX_D_VLD = 1'b0; i_RX_P_DATA = '0; i_RdData = '0;
    i_RdData_Valid = 1'b0; i_ALU_OUT = '0; i_OUT_VALID = 1'b0; i_full_FIFO = 1'b0;
    @(posedge i_clk);
    @(negedge i_clk);
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check_val("reset_busy", 64'(obs_busy), 64'(0));
    idle(1'b0);

    // Write path.
    rx(8'hAA); rx(8'h05); rx(8'h3C);
    check_val("wr_en", 64'(obs_wren), 64'(1));
    check_val("wr_addr", 64'(obs_addr), 64'(5));
    check_val("wr_data", 64'(obs_wrdata), 64'(8'h3C));
    idle(1'b0);
    check_val("wr_idle", 64'(obs_busy), 64'(0));

    // Read path with the TX FIFO full for three cycles.
    rx(8'hBB); rx(8'h07);
    check_val("rd_en", 64'(obs_rden), 64'(1));
    check_val("rd_addr", 64'(obs_addr), 64'(7));
    step(1'b1, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b1);
      check_val("rd_hold_full", 64'(obs_txvld), 64'(0));
    end
    idle(1'b0);
    check_val("rd_tx_vld", 64'(obs_txvld), 64'(1));
    check_val("rd_tx_data", 64'(obs_txdata), 64'(8'h5A));
    idle(1'b0);
    check_val("rd_idle", 64'({obs_busy, obs_txvld}), 64'(0));

    // Wide ALU result.
    rx(8'hCC); rx(8'h11);
    check_val("opa", 64'({obs_wren, obs_addr, obs_wrdata}), 64'({1'b1, 4'd0, 8'h11}));
    rx(8'h22);
    check_val("opb", 64'({obs_wren, obs_addr, obs_wrdata}), 64'({1'b1, 4'd1, 8'h22}));
    rx(8'h02);
    check_val("fun", 64'({obs_en, obs_fun}), 64'({1'b1, 4'd2}));
    idle(1'b0); idle(1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      idle(1'b0);
      check_val("alu_tx_byte", 64'({obs_txvld, obs_txdata}), 64'({1'b1, exp_bytes[k]}));
    end
    idle(1'b0);
    check_val("alu_idle", 64'({obs_busy, obs_txvld}), 64'(0));

    // Bad command.
    rx(8'h77);
    idle(1'b0);
    check_val("bad_cmd_pulse", 64'({obs_errc, obs_busy}), 64'(2'b10));
    idle(1'b0);
    check_val("bad_cmd_once", 64'(obs_errc), 64'(0));

    // Timeout after a lone AA, then a normal write.
    rx(8'hAA);
    for (int i = 0; i < TO; i++) begin
      idle(1'b0);
      check_val("to_quiet", 64'(obs_errt), 64'(0));
    end
    idle(1'b0);
    check_val("to_pulse", 64'({obs_errt, obs_busy}), 64'(2'b10));
    rx(8'hAA); rx(8'h01); rx(8'hFF);
    check_val("post_to_write", 64'({obs_wren, obs_addr, obs_wrdata}), 64'({1'b1, 4'd1, 8'hFF}));

    // Reset in the middle of a transmit.
    rx(8'hCC); rx(8'h01); rx(8'h02); rx(8'h00);
    step(1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 32'h0000A1B2, 1'b0);
    idle(1'b0);
    check_val("mid_tx_b0", 64'({obs_txvld, obs_txdata}), 64'({1'b1, 8'hB2}));
    step(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 32'h0, 1'b0);
    check_val("rst_tx_vld", 64'({obs_txvld, obs_busy}), 64'(0));
    for (int i = 0; i < 4; i++) begin
      idle(1'b0);
      check_val("post_rst_quiet", 64'({obs_txvld, obs_busy, obs_errc, obs_errt}), 64'(0));
    end

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      rst_r  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      vld_r  = ($urandom_range(0, 9) < 4);
      d_r    = ($urandom_range(0, 1) == 1) ? cmds[$urandom_range(0, 3)] : 8'($urandom_range(0, 255));
      rdv_r  = ($urandom_range(0, 4) == 0);
      rdd_r  = 8'($urandom_range(0, 255));
      ov_r   = ($urandom_range(0, 4) == 0);
      alu_r  = $urandom;
      full_r = ($urandom_range(0, 9) < 3);
      step(rst_r, vld_r, d_r, rdv_r, rdd_r, ov_r, alu_r, full_r);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
